// File: rtl/nn_weight_loader_pkg.sv
// Shared types and helpers for the neuron configuration loader.
// Holds the loader state encoding, bus width and sign-extension helper.
package nn_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } loader_state_t;

    localparam int CFG_WIDTH = 32;
    localparam int CNT_WIDTH = 16;

    // Sign-extends the low `width` bits of `data` to the full bus width.
    function automatic logic [CFG_WIDTH-1:0] sext_cfg(input logic [CFG_WIDTH-1:0] data,
                                                      input int unsigned width);
        logic signed [CFG_WIDTH-1:0] t;
        t = $signed(data << (CFG_WIDTH - width));
        return $unsigned(t >>> (CFG_WIDTH - width));
    endfunction

endpackage

// File: rtl/nn_weight_loader_if.sv
// Source-memory read port plus neuron configuration bus driven by the loader.
// The loader is the master; memory and neurons sit on the slave side.
interface nn_weight_loader_if #(
    parameter int dataWidth = 8,
    parameter int addrWidth = 16
) ();
    import nn_cfg_pkg::*;

    logic [addrWidth-1:0] memAddr;
    logic                 memReadEn;
    logic [dataWidth-1:0] memData;
    logic                 weightValid;
    logic                 weightWriteEn;
    logic                 biasWriteEn;
    logic [CFG_WIDTH-1:0] weightData;
    logic [CFG_WIDTH-1:0] biasData;
    logic [CFG_WIDTH-1:0] config_layer_number;
    logic [CFG_WIDTH-1:0] config_neuron_number;

    modport master (
        output memAddr, memReadEn,
        input  memData,
        output weightValid, weightWriteEn, biasWriteEn, weightData, biasData,
        output config_layer_number, config_neuron_number
    );

    modport slave (
        input  memAddr, memReadEn,
        output memData,
        input  weightValid, weightWriteEn, biasWriteEn, weightData, biasData,
        input  config_layer_number, config_neuron_number
    );

endinterface

// File: rtl/nn_weight_loader_cfg_addr_gen.sv
// Source address counter with word/neuron position tracking for one layer.
// is_bias flags the last word of a neuron; last flags the final word of the layer.
module cfg_addr_gen import nn_cfg_pkg::*; #(
    parameter int addrWidth = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 advance,
    input  logic [addrWidth-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0] num_neurons,
    input  logic [CNT_WIDTH-1:0] num_weights,
    output logic [addrWidth-1:0] addr,
    output logic [CNT_WIDTH-1:0] n_idx,
    output logic                 is_bias,
    output logic                 last
);

    logic [addrWidth-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0] w_idx_q, w_idx_d;
    logic [CNT_WIDTH-1:0] n_idx_q, n_idx_d;
    logic [CNT_WIDTH-1:0] w_last_q, w_last_d;
    logic [CNT_WIDTH-1:0] n_last_q, n_last_d;

    always_comb begin
        addr_d   = addr_q;
        w_idx_d  = w_idx_q;
        n_idx_d  = n_idx_q;
        w_last_d = w_last_q;
        n_last_d = n_last_q;
        if (load) begin
            addr_d   = base_addr;
            w_idx_d  = '0;
            n_idx_d  = '0;
            w_last_d = num_weights;
            n_last_d = num_neurons - 1'b1;
        end else if (advance) begin
            addr_d = addr_q + 1'b1;
            if (w_idx_q == w_last_q) begin
                w_idx_d = '0;
                n_idx_d = n_idx_q + 1'b1;
            end else begin
                w_idx_d = w_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            w_idx_q  <= '0;
            n_idx_q  <= '0;
            w_last_q <= '0;
            n_last_q <= '0;
        end else begin
            addr_q   <= addr_d;
            w_idx_q  <= w_idx_d;
            n_idx_q  <= n_idx_d;
            w_last_q <= w_last_d;
            n_last_q <= n_last_d;
        end
    end

    assign addr    = addr_q;
    assign n_idx   = n_idx_q;
    assign is_bias = (w_idx_q == w_last_q);
    assign last    = is_bias && (n_idx_q == n_last_q);

endmodule

// File: rtl/nn_weight_loader.sv
// Walks a packed weight/bias block in source memory and broadcasts it on the
// neuron configuration bus, one word per cycle, for one layer per start.
module nn_weight_loader import nn_cfg_pkg::*; #(
    parameter int dataWidth  = 8,
    parameter int addrWidth  = 16,
    parameter int maxNeurons = 64,
    parameter int maxWeights = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CFG_WIDTH-1:0] layerIn,
    input  logic [CNT_WIDTH-1:0] numNeuronsIn,
    input  logic [CNT_WIDTH-1:0] numWeightsIn,
    input  logic [addrWidth-1:0] baseAddr,
    nn_weight_loader_if.master   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 cfgError
);

    loader_state_t        state_q, state_d;
    logic [CFG_WIDTH-1:0] layer_q, layer_d;
    logic                 cfg_error_q, cfg_error_d;
    logic                 tag_valid_q, tag_valid_d;
    logic                 tag_bias_q, tag_bias_d;
    logic [CNT_WIDTH-1:0] tag_n_q, tag_n_d;

    logic                 load, advance, cfg_ok, run, active;
    logic [addrWidth-1:0] gen_addr;
    logic [CNT_WIDTH-1:0] gen_n;
    logic                 gen_is_bias, gen_last;
    logic [CFG_WIDTH-1:0] write_data;

    cfg_addr_gen #(.addrWidth(addrWidth)) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .advance     (advance),
        .base_addr   (baseAddr),
        .num_neurons (numNeuronsIn),
        .num_weights (numWeightsIn),
        .addr        (gen_addr),
        .n_idx       (gen_n),
        .is_bias     (gen_is_bias),
        .last        (gen_last)
    );

    assign cfg_ok = (numNeuronsIn != '0) && (numNeuronsIn <= CNT_WIDTH'(maxNeurons)) &&
                    (numWeightsIn != '0) && (numWeightsIn <= CNT_WIDTH'(maxWeights));

    always_comb begin
        state_d     = state_q;
        layer_d     = layer_q;
        cfg_error_d = 1'b0;
        load        = 1'b0;
        advance     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        load    = 1'b1;
                        layer_d = layerIn;
                        state_d = RUN;
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end
            end
            RUN: begin
                advance = 1'b1;
                if (gen_last) state_d = DRAIN;
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Tag travels one cycle behind the read so it lines up with memData.
    assign run         = (state_q == RUN);
    assign active      = run || (state_q == DRAIN);
    assign tag_valid_d = run;
    assign tag_bias_d  = run && gen_is_bias;
    assign tag_n_d     = run ? gen_n : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            layer_q     <= '0;
            cfg_error_q <= 1'b0;
            tag_valid_q <= 1'b0;
            tag_bias_q  <= 1'b0;
            tag_n_q     <= '0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            cfg_error_q <= cfg_error_d;
            tag_valid_q <= tag_valid_d;
            tag_bias_q  <= tag_bias_d;
            tag_n_q     <= tag_n_d;
        end
    end

    always_comb begin
        write_data               = tag_valid_q ? sext_cfg(CFG_WIDTH'(bus.memData), dataWidth) : '0;
        bus.memReadEn            = run;
        bus.memAddr              = run ? gen_addr : '0;
        bus.weightValid          = active;
        bus.weightWriteEn        = tag_valid_q && !tag_bias_q;
        bus.biasWriteEn          = tag_valid_q && tag_bias_q;
        bus.weightData           = write_data;
        bus.biasData             = write_data;
        bus.config_neuron_number = tag_valid_q ? CFG_WIDTH'(tag_n_q) : '0;
        bus.config_layer_number  = active ? layer_q : '0;
        busy                     = active;
        done                     = (state_q == DONE);
        cfgError                 = cfg_error_q;
    end

endmodule

// File: tb/tb_nn_weight_loader.sv
// Directed bench for nn_weight_loader: timeline model checked every cycle plus
// literal expectations for the reference load, sign extension, errors and wrap.
module tb_nn_weight_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] layerIn = '0;
    logic [15:0] numN = '0, numW = '0;
    logic [15:0] baseAddr = '0;
    logic        busy, done, cfgError;

    logic        startB = 1'b0;
    logic [3:0]  baseB = '0;
    logic        busyB, doneB, cfgErrorB;

    logic [7:0]  mem_a [65536];
    logic [7:0]  mem_b [16];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nn_weight_loader_if #(.dataWidth(8), .addrWidth(16)) ifa ();
    nn_weight_loader_if #(.dataWidth(8), .addrWidth(4))  ifb ();

    nn_weight_loader #(.dataWidth(8), .addrWidth(16), .maxNeurons(64), .maxWeights(256)) dut (
        .clk(clk), .reset(rst), .start(start), .layerIn(layerIn),
        .numNeuronsIn(numN), .numWeightsIn(numW), .baseAddr(baseAddr),
        .bus(ifa), .busy(busy), .done(done), .cfgError(cfgError)
    );

    nn_weight_loader #(.dataWidth(8), .addrWidth(4), .maxNeurons(64), .maxWeights(256)) dut_b (
        .clk(clk), .reset(rst), .start(startB), .layerIn(32'd9),
        .numNeuronsIn(16'd1), .numWeightsIn(16'd2), .baseAddr(baseB),
        .bus(ifb), .busy(busyB), .done(doneB), .cfgError(cfgErrorB)
    );

    always @(posedge clk) if (ifa.memReadEn) ifa.memData <= mem_a[ifa.memAddr];
    always @(posedge clk) if (ifb.memReadEn) ifb.memData <= mem_b[ifb.memAddr];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        chk(name, {31'd0, got}, {31'd0, exp});
    endtask

    function automatic logic [31:0] m_sext8(input logic [7:0] b);
        int s;
        s = int'(b);
        if (s > 127) s = s - 256;
        return 32'(s);
    endfunction

    // Model: a load is a timeline k = 1..T+2 cycles after the accepted start.
    int m_act = 0, m_err = 0, m_k = 0, m_N = 0, m_W = 0, m_T = 0, m_base = 0;
    logic [31:0] m_layer = '0;

    initial forever begin
        int was;
        @(posedge clk);
        was = m_act;
        m_err = 0;
        if (rst) begin
            m_act = 0;
        end else begin
            if (m_act != 0) begin
                m_k++;
                if (m_k > m_T + 2) m_act = 0;
            end
            if (was == 0 && start) begin
                if (numN >= 1 && numN <= 64 && numW >= 1 && numW <= 256) begin
                    m_act = 1; m_k = 1;
                    m_N = int'(numN); m_W = int'(numW);
                    m_T = m_N * (m_W + 1);
                    m_base = int'(baseAddr); m_layer = layerIn;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_act == 0) begin
            chk1("idle_rd", ifa.memReadEn, 1'b0);
            chk1("idle_busy", busy, 1'b0);
            chk1("idle_valid", ifa.weightValid, 1'b0);
            chk1("idle_ww", ifa.weightWriteEn, 1'b0);
            chk1("idle_bw", ifa.biasWriteEn, 1'b0);
            chk1("idle_done", done, 1'b0);
            chk("idle_addr", 32'(ifa.memAddr), 32'd0);
            chk("idle_wdata", ifa.weightData, 32'd0);
            chk("idle_layer", ifa.config_layer_number, 32'd0);
            chk("idle_neuron", ifa.config_neuron_number, 32'd0);
            chk1("cfg_err", cfgError, m_err != 0);
        end else begin
            chk1("rd_en", ifa.memReadEn, m_k <= m_T);
            if (m_k <= m_T) chk("mem_addr", 32'(ifa.memAddr), 32'(16'(m_base + m_k - 1)));
            chk1("busy", busy, m_k <= m_T + 1);
            chk1("valid", ifa.weightValid, m_k <= m_T + 1);
            chk1("done", done, m_k == m_T + 2);
            chk1("cfg_err_run", cfgError, 1'b0);
            if (m_k >= 2 && m_k <= m_T + 1) begin
                int j;
                logic isb;
                logic [31:0] ev;
                j   = m_k - 2;
                isb = (j % (m_W + 1)) == m_W;
                ev  = m_sext8(mem_a[16'(m_base + j)]);
                chk1("wr_w", ifa.weightWriteEn, !isb);
                chk1("wr_b", ifa.biasWriteEn, isb);
                chk("neuron", ifa.config_neuron_number, 32'(j / (m_W + 1)));
                chk("layer", ifa.config_layer_number, m_layer);
                if (isb) chk("bias_data", ifa.biasData, ev);
                else     chk("weight_data", ifa.weightData, ev);
            end else begin
                chk1("no_wr_w", ifa.weightWriteEn, 1'b0);
                chk1("no_wr_b", ifa.biasWriteEn, 1'b0);
            end
        end
    end

    logic [31:0] obs_d [$];
    logic [31:0] obs_n [$];
    logic        obs_b [$];
    int done_cyc, n_done;

    task automatic do_start(input int n, input int w, input logic [15:0] base, input logic [31:0] layer);
        @(negedge clk);
        start = 1'b1; numN = 16'(n); numW = 16'(w); baseAddr = base; layerIn = layer;
        @(negedge clk);
        start = 1'b0; numN = 16'hFFFF; numW = 16'h0; baseAddr = 16'hBEEF; layerIn = 32'hA5A5_0000;
    endtask

    // Observes cycles 1..cycles after a start; optionally re-pulses start at poke.
    task automatic capture(input int cycles, input int poke);
        obs_d.delete(); obs_n.delete(); obs_b.delete();
        done_cyc = 0; n_done = 0;
        for (int c = 1; c <= cycles; c++) begin
            if (c > 1) @(negedge clk);
            start = (c == poke);
            if (c == poke) begin numN = 16'd1; numW = 16'd1; baseAddr = 16'h40; end
            if (ifa.weightWriteEn) begin obs_d.push_back(ifa.weightData); obs_n.push_back(ifa.config_neuron_number); obs_b.push_back(1'b0); end
            if (ifa.biasWriteEn)   begin obs_d.push_back(ifa.biasData);   obs_n.push_back(ifa.config_neuron_number); obs_b.push_back(1'b1); end
            if (done) begin n_done++; if (done_cyc == 0) done_cyc = c; end
        end
        start = 1'b0;
    endtask

    task automatic check_ref_seq(input string tag);
        logic [31:0] exp_d [8] = '{32'h1, 32'h2, 32'h3, 32'h7F, 32'h4, 32'h5, 32'h6, 32'hFFFFFF80};
        logic [31:0] exp_n [8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1};
        logic        exp_b [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        chk({tag, "_n_writes"}, 32'(obs_d.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_data"},   (i < obs_d.size()) ? obs_d[i] : 32'hDEADBEEF, exp_d[i]);
            chk({tag, "_neuron"}, (i < obs_n.size()) ? obs_n[i] : 32'hDEADBEEF, exp_n[i]);
            chk1({tag, "_isbias"}, (i < obs_b.size()) ? obs_b[i] : 1'bx, exp_b[i]);
        end
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'd10);
        chk({tag, "_done_count"}, 32'(n_done), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < 16; i++) mem_b[i] = 8'h00;
        mem_a[16'h10] = 8'h01; mem_a[16'h11] = 8'h02; mem_a[16'h12] = 8'h03; mem_a[16'h13] = 8'h7F;
        mem_a[16'h14] = 8'h04; mem_a[16'h15] = 8'h05; mem_a[16'h16] = 8'h06; mem_a[16'h17] = 8'h80;
        mem_a[16'h40] = 8'hFF; mem_a[16'h41] = 8'h7F;
        mem_b[4'hE] = 8'h11; mem_b[4'hF] = 8'h22; mem_b[4'h0] = 8'h93;

        chk("model_sext_ff", m_sext8(8'hFF), 32'hFFFFFFFF);
        chk("model_sext_7f", m_sext8(8'h7F), 32'h0000007F);

        repeat (3) @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rd", ifa.memReadEn, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_cfg_err", cfgError, 1'b0);
        chk1("rst_b_busy", busyB, 1'b0);
        rst = 1'b0;

        // Reference load N=2, W=3 at 0x10.
        do_start(2, 3, 16'h10, 32'd5);
        capture(14, 0);
        check_ref_seq("ref");

        // Sign extension on both strobes.
        do_start(1, 1, 16'h40, 32'd7);
        @(negedge clk);
        chk1("sext_ww", ifa.weightWriteEn, 1'b1);
        chk("sext_ff", ifa.weightData, 32'hFFFFFFFF);
        @(negedge clk);
        chk1("sext_bw", ifa.biasWriteEn, 1'b1);
        chk("sext_7f", ifa.biasData, 32'h0000007F);
        repeat (2) @(negedge clk);

        // Out-of-range counts.
        do_start(0, 3, 16'h10, 32'd1);
        chk1("bad_n_err", cfgError, 1'b1);
        chk1("bad_n_busy", busy, 1'b0);
        chk1("bad_n_rd", ifa.memReadEn, 1'b0);
        @(negedge clk);
        chk1("bad_n_err_pulse", cfgError, 1'b0);
        do_start(1, 257, 16'h10, 32'd1);
        chk1("bad_w_err", cfgError, 1'b1);
        chk1("bad_w_busy", busy, 1'b0);
        @(negedge clk);
        chk1("bad_w_err_pulse", cfgError, 1'b0);
        chk1("bad_w_rd", ifa.memReadEn, 1'b0);

        // Start re-pulsed during RUN must be ignored.
        do_start(2, 3, 16'h10, 32'd5);
        capture(14, 3);
        check_ref_seq("ignore");

        // Reset in cycle 4, then a clean replay.
        do_start(2, 3, 16'h10, 32'd5);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk1("mid_rst_rd", ifa.memReadEn, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_ww", ifa.weightWriteEn, 1'b0);
        chk1("mid_rst_bw", ifa.biasWriteEn, 1'b0);
        chk("mid_rst_addr", 32'(ifa.memAddr), 32'd0);
        chk("mid_rst_wdata", ifa.weightData, 32'd0);
        chk("mid_rst_layer", ifa.config_layer_number, 32'd0);
        rst = 1'b0;
        do_start(2, 3, 16'h10, 32'd5);
        capture(14, 0);
        check_ref_seq("replay");

        // Address wrap on the 4-bit instance.
        @(negedge clk);
        startB = 1'b1; baseB = 4'hE;
        @(negedge clk);
        startB = 1'b0; baseB = 4'h3;
        chk("wrap_addr0", 32'(ifb.memAddr), 32'hE);
        chk1("wrap_rd0", ifb.memReadEn, 1'b1);
        @(negedge clk);
        chk("wrap_addr1", 32'(ifb.memAddr), 32'hF);
        chk("wrap_w0", ifb.weightData, 32'h11);
        @(negedge clk);
        chk("wrap_addr2", 32'(ifb.memAddr), 32'h0);
        chk("wrap_w1", ifb.weightData, 32'h22);
        @(negedge clk);
        chk1("wrap_bw", ifb.biasWriteEn, 1'b1);
        chk("wrap_bias", ifb.biasData, 32'hFFFFFF93);
        chk1("wrap_rd_off", ifb.memReadEn, 1'b0);
        @(negedge clk);
        chk1("wrap_done", doneB, 1'b1);
        @(negedge clk);
        chk1("wrap_idle", busyB, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nn_weight_loader.md
# nn_weight_loader

Configuration master for the neural-network datapath. It walks a contiguous block of packed weight/bias words in a read-only memory and drives the neuron configuration bus, so weight and bias memories load at runtime instead of from init files. One instance serves one layer per start command. The neurons on that layer select themselves by comparing `config_layer_number`/`config_neuron_number` against their own layer and neuron parameters.

## Interface
Parameters:
- `dataWidth`, 8, width of a stored weight/bias word in source memory
- `addrWidth`, 16, source memory address width
- `maxNeurons`, 64, upper bound accepted for `numNeuronsIn`
- `maxWeights`, 256, upper bound accepted for `numWeightsIn`

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle load request; sampled only in IDLE
- `layerIn`  in  32  layer number to broadcast
- `numNeuronsIn`  in  16  neurons in layer, 1..maxNeurons
- `numWeightsIn`  in  16  weights per neuron, 1..maxWeights
- `baseAddr`  in  addrWidth  address of first word
- `memAddr`  out  addrWidth  source read address
- `memReadEn`  out  1  source read strobe
- `memData`  in  dataWidth  read data, valid exactly 1 cycle after `memReadEn`
- `weightValid`  out  1  level, high for the whole write window of a layer
- `weightWriteEn`  out  1  strobe: `weightData` is a weight for the addressed neuron
- `biasWriteEn`  out  1  strobe: `biasData` is the bias for the addressed neuron
- `weightData`  out  32  sign-extended `memData`
- `biasData`  out  32  sign-extended `memData`
- `config_layer_number`  out  32  latched `layerIn`
- `config_neuron_number`  out  32  neuron index of the current write
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle completion pulse
- `cfgError`  out  1  one-cycle pulse when `start` carries an out-of-range count

## Operation
- Memory layout: for each neuron n = 0..N-1, W weight words (weight 0 first) followed by 1 bias word. The layer occupies T = N·(W+1) words starting at `baseAddr`.
- FSM states:
  - IDLE, all outputs 0:
    - `start` with 1≤N≤maxNeurons and 1≤W≤maxWeights: latch N, W, `layerIn`, `baseAddr`, then go to RUN.
    - `start` with an out-of-range N or W: pulse `cfgError` and stay in IDLE.
  - RUN: `memReadEn`=1 every cycle and `memAddr` increments by 1 per cycle. Word counter wIdx runs 0..W, where wIdx=W marks the bias word. Neuron counter nIdx runs 0..N-1. After issuing word T-1, go to DRAIN.
  - DRAIN: `memReadEn`=0; the last word is written. Then go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Write stage: a one-deep tag pipeline carries {isBias, nIdx} alongside each read. In the cycle after an issue:
  - `weightWriteEn`=!isBias and `biasWriteEn`=isBias; never both.
  - `config_neuron_number` is the tagged nIdx, zero-extended.
  - Data is `memData` sign-extended from bit dataWidth-1. Both `weightData` and `biasData` carry it; only the matching strobe qualifies it.
- `start` outside IDLE is ignored. `layerIn`, `numNeuronsIn`, `numWeightsIn` and `baseAddr` may change freely after the start cycle.
- `memAddr` wraps modulo 2^addrWidth with no error.
- `reset` at any point, including mid-load: on the next edge the FSM is in IDLE, all counters are 0 and all outputs are 0. No partial-write cleanup is performed.

## Timing
- `start` is sampled at edge 0.
- `memReadEn` is high in cycles 1..T, and `memAddr` = baseAddr+k in cycle k+1.
- Write strobes occur in cycles 2..T+1; the first-to-write latency is 2 cycles.
- `busy` and `weightValid` are high in cycles 1..T+1.
- `done` is high in cycle T+2. A new `start` is accepted from cycle T+3.
- Throughput is one word per cycle; there are no bubbles between neurons.
- Reset values: every output is 0.

## Structure
- Package `nn_cfg_pkg`:
  - state enum `loader_state_t` {IDLE, RUN, DRAIN, DONE}
  - `CFG_WIDTH`=32
  - function `sext_cfg(data, width)`
- Sub-module `cfg_addr_gen`: address counter plus wIdx/nIdx counters and the last-word flag, with load/advance inputs. The loader top holds the FSM, the tag pipeline and the output registers.

## Test plan
- N=2, W=3, base=0x10, memory = 0x01,0x02,0x03,0x7F,0x04,0x05,0x06,0x80:
  - weight writes n0: 1,2,3; bias n0: 127
  - weight writes n1: 4,5,6; bias n1: 0xFFFFFF80
  - `done` in cycle 10
- Sign extension: dataWidth=8, word 0xFF → `weightData`=0xFFFFFFFF; word 0x7F → 0x0000007F.
- Bad config: `start` with N=0, or W=maxWeights+1 → `cfgError` for one cycle, `busy` stays 0, no reads.
- `start` pulsed again during RUN → ignored; total writes still T, single `done`.
- `reset` in cycle 4 of the N=2, W=3 load → all outputs 0 next cycle. A following `start` replays from `baseAddr` with a correct full sequence.
- Wrap: addrWidth=4, base=0xE, N=1, W=2 → `memAddr` sequence 0xE, 0xF, 0x0; bias is read from address 0x0.
